// File: rtl/mag_comp_pkg.sv
// Shared definitions for the pipelined magnitude comparator.
// Result codes are packed as {g, e, l}, so exactly one bit is set.
package mag_comp_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    // Map a combined (greater, equal) decision onto a one-hot result code.
    function automatic logic [2:0] res_code(input logic gt, input logic eq);
        if (eq) begin
            return EQ;
        end else if (gt) begin
            return GT;
        end else begin
            return LT;
        end
    endfunction

endpackage

// File: rtl/mag_comp_pipe_seg_cmp.sv
// Combinational unsigned compare of one SEG-bit operand segment.
module seg_cmp #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    output logic           gt_o,
    output logic           eq_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/mag_comp_pipe.sv
// Two-stage elastic magnitude comparator.
//   S1: per-segment greater/equal flags, one seg_cmp per SEG-bit slice.
//   S2: MSB-first combine into a one-hot {g, e, l} result.
// Optional feature: define MAG_COMP_SIGNED_EN to add the sgn input; when sgn
// is 1 the operands are compared as two's complement by inverting both sign
// bits before the segment compare (sgn is consumed together with its a/b).
module mag_comp_pipe
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             g,
    output logic             e,
    output logic             l,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MAG_COMP_SIGNED_EN
    ,
    input  logic             sgn
`endif
);

    localparam int NSEG = WIDTH / SEG;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [NSEG-1:0]  gt_seg;
    logic [NSEG-1:0]  eq_seg;

    logic             vld_p1_q, vld_p1_d;
    logic [NSEG-1:0]  gt_p1_q, gt_p1_d;
    logic [NSEG-1:0]  eq_p1_q, eq_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [2:0]       res_p2_q, res_p2_d;

    logic             adv_p2;
    logic             adv_p1;
    logic             gt_c;
    logic             eq_c;
    logic             found;

    // Flow control: a stage moves when it is empty or its successor moves.
    assign adv_p2   = !vld_p2_q || out_ready;
    assign adv_p1   = !vld_p1_q || adv_p2;
    assign in_ready = adv_p1;

    // Operand conditioning ahead of the segment compare (sign-bit flip).
    always_comb begin
        a_cmp = a;
        b_cmp = b;
`ifdef MAG_COMP_SIGNED_EN
        if (sgn) begin
            a_cmp[WIDTH-1] = ~a[WIDTH-1];
            b_cmp[WIDTH-1] = ~b[WIDTH-1];
        end
`endif
    end

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        seg_cmp #(.SEG(SEG)) u_seg_cmp (
            .a_i  (a_cmp[i*SEG +: SEG]),
            .b_i  (b_cmp[i*SEG +: SEG]),
            .gt_o (gt_seg[i]),
            .eq_o (eq_seg[i])
        );
    end

    // ---- stage 0 -> stage 1 boundary ----
    // S1 next state: capture fresh flags on an input transfer.
    always_comb begin
        vld_p1_d = vld_p1_q;
        gt_p1_d  = gt_p1_q;
        eq_p1_d  = eq_p1_q;
        if (adv_p1) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                gt_p1_d = gt_seg;
                eq_p1_d = eq_seg;
            end
        end
    end

    // S1 register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            gt_p1_q  <= '0;
            eq_p1_q  <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            gt_p1_q  <= gt_p1_d;
            eq_p1_q  <= eq_p1_d;
        end
    end

    // ---- stage 1 -> stage 2 boundary ----
    // S2 next state: the highest non-equal segment decides greater vs less.
    always_comb begin
        found = 1'b0;
        gt_c  = 1'b0;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (!found && !eq_p1_q[i]) begin
                found = 1'b1;
                gt_c  = gt_p1_q[i];
            end
        end
        eq_c     = &eq_p1_q;
        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                res_p2_d = res_code(gt_c, eq_c);
            end
        end
    end

    // S2 register with synchronous reset; holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
        end
    end

    assign g         = res_p2_q[2];
    assign e         = res_p2_q[1];
    assign l         = res_p2_q[0];
    assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_mag_comp_pipe.sv
// Self-checking bench for mag_comp_pipe (WIDTH=16, SEG=4).
module tb_mag_comp_pipe;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic        g;
    logic        e;
    logic        l;
    logic        out_valid;
    logic        out_ready;
`ifdef MAG_COMP_SIGNED_EN
    logic        sgn;
`endif

    int total = 0;
    int bad   = 0;
    int n_in  = 0;
    bit mon_en = 1'b0;
    logic [2:0] exp_q[$];

    vec_t dir_v[7];
    vec_t bp_v[4];
    int   exp_rdy[5];

    always #5 clk = ~clk;

    mag_comp_pipe #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .e         (e),
        .l         (l),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MAG_COMP_SIGNED_EN
        ,
        .sgn       (sgn)
`endif
    );

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unsigned magnitude relation straight from the operand values.
    function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y);
        if (x > y)       return R_GT;
        else if (x == y) return R_EQ;
        else             return R_LT;
    endfunction

    // Scoreboard for the random stream, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                chk("onehot", $countones({g, e, l}), 1);
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                    else chk("rand_res", {g, e, l}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                n_in++;
            end
        end
    end

    initial begin
        int k;
        int kk;
        int cyc;
        logic [15:0] ra;
        logic [15:0] rb;

        dir_v[0] = '{16'h1234, 16'h1233, R_GT};
        dir_v[1] = '{16'hFFFF, 16'hFFFF, R_EQ};
        dir_v[2] = '{16'h0000, 16'h0001, R_LT};
        dir_v[3] = '{16'h8000, 16'h7FFF, R_GT};
        dir_v[4] = '{16'h0000, 16'h0000, R_EQ};
        dir_v[5] = '{16'h00F0, 16'h0F00, R_LT};
        dir_v[6] = '{16'h1F00, 16'h1EFF, R_GT};
        bp_v[0]  = '{16'h0005, 16'h0003, R_GT};
        bp_v[1]  = '{16'h0007, 16'h0007, R_EQ};
        bp_v[2]  = '{16'h0001, 16'h0009, R_LT};
        bp_v[3]  = '{16'hA000, 16'h9FFF, R_GT};
        exp_rdy  = '{1, 1, 0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef MAG_COMP_SIGNED_EN
        sgn = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_gel", {g, e, l}, 0);
        chk("rst_in_ready", in_ready, 1);

        // Back-to-back directed vectors: result two cycles after presentation.
        for (int c = 0; c < 9; c++) begin
            if (c < 7) begin
                a = dir_v[c].a; b = dir_v[c].b; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("dir_in_ready", in_ready, 1);
            if (c >= 2) begin
                chk("dir_out_valid", out_valid, 1);
                chk("dir_res", {g, e, l}, dir_v[c-2].exp);
            end else begin
                chk("dir_latency", out_valid, 0);
            end
            tick();
        end
        tick();
        chk("dir_drained", out_valid, 0);

        // Backpressure: four offered while the sink stalls five cycles.
        k = 0;
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            in_valid  = (k < 4);
            kk = (k < 4) ? k : 0;
            a = bp_v[kk].a; b = bp_v[kk].b;
            #1;
            chk("bp_in_ready", in_ready, exp_rdy[c]);
            if (c >= 2) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_res", {g, e, l}, bp_v[0].exp);
            end
            if (in_ready && in_valid) k++;
            tick();
        end
        chk("bp_accepted", k, 2);
        for (int c = 0; c < 4; c++) begin
            out_ready = 1'b1;
            in_valid  = (k < 4);
            kk = (k < 4) ? k : 0;
            a = bp_v[kk].a; b = bp_v[kk].b;
            #1;
            chk("bp_rel_valid", out_valid, 1);
            chk("bp_rel_res", {g, e, l}, bp_v[c].exp);
            if (in_ready && in_valid) k++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_all_in", k, 4);
        chk("bp_drained", out_valid, 0);

        // Reset with both stages full discards everything.
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h0003; b = 16'h0003;
        tick(); tick();
        chk("full_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_gel", {g, e, l}, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("no_stale", out_valid, 0);
        end

`ifdef MAG_COMP_SIGNED_EN
        sgn = 1'b1; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
        tick();
        sgn = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("signed_lt", {g, e, l}, R_LT);
        tick();
        chk("unsigned_gt", {g, e, l}, R_GT);
        tick();
`endif

        // Random stream with random backpressure against the model.
        mon_en = 1'b1;
        cyc = 0;
        while (n_in < 10000 && cyc < 60000) begin
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            a = ra; b = rb;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_budget", (n_in >= 10000) ? 1 : 0, 1);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        tick();
        chk("rand_drain", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
